// File: rtl/store_buffer.sv
// Store buffer: a FIFO of word stores between execute and a single-ported data memory.
// It shares the memory address bus with loads. Define STORE_FWD_EN to forward load hits from pending stores.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [AW-1:0]            st_addr,
    input  logic [DW-1:0]            st_data,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    output logic                     ld_stall,
    output logic [DW-1:0]            ld_data,
    input  logic [DW-1:0]            mem_rd,
    output logic [AW-1:0]            mem_a,
    output logic [DW-1:0]            mem_wd,
    output logic                     mem_we,
    input  logic                     flush_req,
    output logic                     flush_done,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];

    logic full, nonempty, enq, drain;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    assign full     = (count_q == CW'(DEPTH));
    assign nonempty = (count_q != '0);

    // A slot freed by a same-cycle drain is not reused until the next cycle.
    assign st_ready = rst && !full && !flush_req;
    assign enq      = st_valid && st_ready;

`ifdef STORE_FWD_EN
    // Loads only lose the bus to a full buffer or a fence.
    assign ld_stall = rst && ld_valid && nonempty && (full || flush_req);
    assign drain    = rst && nonempty && (!ld_valid || full || flush_req);

    logic [DEPTH-1:0] slot_hit;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [PW-1:0] age;
        assign age         = PW'(gi) - head_q;
        assign slot_hit[gi] = ({1'b0, age} < count_q) && (addr_q[gi] == ld_addr);
    end

    // Walk from oldest to youngest so the youngest match is the one kept.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (slot_hit[idx]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
`else
    // Without forwarding any load waits until every pending store has reached memory.
    assign ld_stall = rst && ld_valid && nonempty;
    assign drain    = rst && nonempty;
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign mem_we     = drain;
    assign mem_a      = drain ? addr_q[head_q] : ld_addr;
    assign mem_wd     = data_q[head_q];
    assign ld_data    = ld_stall ? '0 : (fwd_hit ? fwd_data : mem_rd);
    assign flush_done = (count_q == '0);
    assign count      = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            tail_d = tail_q + 1'b1;
        end
        if (drain) begin
            head_d = head_q + 1'b1;
        end
        if (enq && !drain) begin
            count_d = count_q + 1'b1;
        end else if (!enq && drain) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads need no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= st_addr;
            data_q[tail_q] <= st_data;
        end
    end
endmodule
